ast_symbol_packer: RTL
======================

Name: ast_symbol_packer

Overview:
- Avalon-ST width adapter upstream of the streaming FIFO wrapper.
- Accepts one DATABITS_PER_SYMBOL symbol per cycle with packet framing and packs SYMBOLS_PER_BEAT symbols into one beat on the FIFO write side.
- Pads short final beats and reports the unused symbol count on src_empty_o.
- Single registered output stage; ready latency 0 on both sides.

Parameters:
- DATABITS_PER_SYMBOL, 8, bits per symbol.
- SYMBOLS_PER_BEAT, 4, symbols per output beat; must be at least 2.
- EMPTY_W, $clog2(SYMBOLS_PER_BEAT), width of the empty field; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- snk_data_i  in  DATABITS_PER_SYMBOL  input symbol.
- snk_valid_i  in  1  input symbol valid.
- snk_sop_i  in  1  first symbol of a packet.
- snk_eop_i  in  1  last symbol of a packet.
- snk_ready_o  out  1  symbol accepted when snk_valid_i and snk_ready_o are both high.
- src_data_o  out  SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL  packed beat; first symbol in the MSBs.
- src_valid_o  out  1  beat valid; connects to the FIFO write valid.
- src_sop_o  out  1  beat holds the packet's first symbol.
- src_eop_o  out  1  beat holds the packet's last symbol.
- src_empty_o  out  EMPTY_W  unused low-order symbols; meaningful only when src_eop_o is high.
- src_ready_i  in  1  downstream ready (FIFO non-full).
- err_o  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst_i low, asynchronous): src_valid_o, src_sop_o, src_eop_o, src_empty_o, err_o, the symbol count and the in-packet flag all clear to 0. src_data_o and the accumulator clear to 0. Reset asserted mid-packet discards all partial and pending data.
- snk_ready_o = !src_valid_o || src_ready_i. It is combinational from src_ready_i and never depends on snk_valid_i.
- Accumulator:
  - cnt ranges 0..SYMBOLS_PER_BEAT-1.
  - An accepted symbol is written to slot cnt. Slot 0 is bits [W-1 : W-DATABITS_PER_SYMBOL].
  - When cnt==0, the other slots are zeroed so padding is always 0.
- Beat completion: an accepted symbol completes a beat when cnt==SYMBOLS_PER_BEAT-1 or snk_eop_i is high. On the next edge:
  - the output register loads the accumulator plus this symbol;
  - src_valid_o goes to 1;
  - src_sop_o takes the latched sop-of-beat flag;
  - src_eop_o takes snk_eop_i;
  - src_empty_o = SYMBOLS_PER_BEAT-1-cnt when eop, otherwise 0;
  - cnt goes to 0.
- Latency: the last symbol of a beat is accepted at edge N; the beat is visible from edge N until it is taken.
- Output hold: while src_valid_o && !src_ready_i, all src_* outputs stay stable. A same-cycle take and reload is allowed: when src_ready_i is high, the register drops the old beat and loads a new completed beat on the same edge. src_valid_o stays high.
- Framing: a two-state FSM, IDLE and IN_PKT.
  - IDLE: on an accepted symbol with snk_sop_i, go to IN_PKT, or stay in IDLE if snk_eop_i is also high (single-symbol packet).
  - IN_PKT: an accepted symbol with snk_eop_i returns to IDLE.
- Errors (err_o pulses on the cycle after acceptance):
  - Symbol accepted in IDLE without snk_sop_i: the symbol is dropped.
  - snk_sop_i accepted in IN_PKT: the partial beat is discarded, cnt is cleared, and the symbol starts a new packet at slot 0.
- No transfer occurs when snk_valid_i is low; the state holds.

Optional Feature:
- Macro: AST_PACKER_STATS_EN.
- When defined:
  - Adds output pkt_cnt_o [15:0], the count of beats emitted with src_eop_o (counted on the output handshake).
  - Adds output err_cnt_o [15:0], the count of err_o pulses.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When not defined: these ports and counters do not exist. The remaining behaviour is identical.

Decomposition:
- Package ast_pkg holds:
  - the FSM state typedef (AST_IDLE, AST_IN_PKT);
  - the default symbol width and beat size constants shared with the FIFO wrapper;
  - a function returning the empty count from cnt.
- One natural sub-module, ast_out_reg: the registered valid/ready output stage with hold and same-cycle take-reload behaviour. It is reusable by other stream stages.

Test Plan:
- 8-symbol packet 0x01..0x08, sop on 0x01, eop on 0x08, src_ready_i held 1:
  - beats 0x01020304 (sop=1, eop=0) and 0x05060708 (sop=0, eop=1, empty=0);
  - snk_ready_o stays at 1 throughout.
- 5-symbol packet 0xA1..0xA5:
  - beats 0xA1A2A3A4 (sop=1), then 0xA5000000 (eop=1, empty=3).
- Single-symbol packet 0x7E with sop and eop together:
  - one beat 0x7E000000, sop=1, eop=1, empty=3;
  - FSM remains IDLE.
- src_ready_i low for 5 cycles while a beat is pending:
  - src_data_o and the framing outputs stay stable;
  - snk_ready_o is 0;
  - no symbol is lost or duplicated after src_ready_i rises.
- Sop while in IN_PKT after 2 symbols (0x11, 0x22), new packet 0x33..0x36:
  - err_o pulses once;
  - output is only 0x33343536 with sop=1;
  - a symbol with no sop while in IDLE is dropped with err_o=1.
- rst_i asserted low mid-beat (cnt=2) with a beat pending:
  - all outputs go to 0 immediately;
  - after release, the next packet packs from slot 0.

Source files
------------

// File: rtl/ast_pkg.sv
// Shared definitions for the Avalon-ST symbol packer and the streaming FIFO wrapper.
// Holds the framing FSM state type, the default symbol and beat sizes, and a helper that
// turns the final symbol's slot index into the beat's empty count.
package ast_pkg;

  typedef enum logic {
    AST_IDLE   = 1'b0,
    AST_IN_PKT = 1'b1
  } ast_state_e;

  localparam int unsigned AST_DATABITS_PER_SYMBOL = 8;
  localparam int unsigned AST_SYMBOLS_PER_BEAT    = 4;

  // Unused low-order symbols in a beat whose last valid symbol sits in slot cnt.
  function automatic int unsigned ast_empty_count(input int unsigned cnt,
                                                  input int unsigned symbols_per_beat);
    return symbols_per_beat - 1 - cnt;
  endfunction

endpackage

// File: rtl/ast_out_reg.sv
// Registered valid/ready output stage with ready latency 0.
// Holds its payload stable while out_valid_o && !out_ready_i. When out_ready_i is high the
// current word is dropped, and a new word may be loaded on the same edge.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   load_valid_i      a new word is presented for loading
//   load_data_i       word to load
//   in_ready_o        stage can accept a word this cycle
//   out_valid_o       registered word is valid
//   out_data_o        registered word
//   out_ready_i       downstream takes the word this cycle
module ast_out_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  input  logic [Width-1:0] load_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ast_symbol_packer.sv
// Avalon-ST width adapter: packs one symbol per cycle into beats of SYMBOLS_PER_BEAT symbols
// (first symbol in the MSBs) with packet framing. Short final beats are zero-padded and
// report their unused symbol count on src_empty_o. err_o pulses for one cycle on a symbol
// received outside a packet (dropped) or a sop received inside a packet (partial beat
// discarded, new packet started).
// Optional build macro AST_PACKER_STATS_EN adds saturating counters pkt_cnt_o (eop beats
// taken downstream) and err_cnt_o (err_o pulses).
// Ports:
//   clk_i, rst_i                                 clock, asynchronous active-low reset
//   snk_data_i/valid_i/sop_i/eop_i, snk_ready_o  symbol input
//   src_data_o/valid_o/sop_o/eop_o/empty_o       beat output, src_ready_i downstream ready
//   err_o                                        framing error pulse
module ast_symbol_packer
  import ast_pkg::*;
#(
  parameter int unsigned DATABITS_PER_SYMBOL = AST_DATABITS_PER_SYMBOL,
  parameter int unsigned SYMBOLS_PER_BEAT    = AST_SYMBOLS_PER_BEAT,
  parameter int unsigned EMPTY_W             = $clog2(SYMBOLS_PER_BEAT)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [DATABITS_PER_SYMBOL-1:0]                snk_data_i,
  input  logic                                          snk_valid_i,
  input  logic                                          snk_sop_i,
  input  logic                                          snk_eop_i,
  output logic                                          snk_ready_o,
  output logic [SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL-1:0] src_data_o,
  output logic                                          src_valid_o,
  output logic                                          src_sop_o,
  output logic                                          src_eop_o,
  output logic [EMPTY_W-1:0]                            src_empty_o,
  input  logic                                          src_ready_i,
  output logic                                          err_o
`ifdef AST_PACKER_STATS_EN
  ,
  output logic [15:0]                                   pkt_cnt_o,
  output logic [15:0]                                   err_cnt_o
`endif
);

  localparam int unsigned DataW = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL;
  localparam int unsigned CntW  = EMPTY_W;
  localparam int unsigned PayW  = DataW + 2 + EMPTY_W;

  ast_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DataW-1:0]   acc_q, acc_d;
  logic               sop_beat_q, sop_beat_d;
  logic               err_q, err_d;

  logic               accept, restart, bad_start, take, complete;
  logic [CntW-1:0]    eff_cnt;
  logic [DataW-1:0]   acc_new;
  logic               beat_sop;
  logic [EMPTY_W-1:0] beat_empty;
  logic [PayW-1:0]    load_data, out_data;

  assign accept    = snk_valid_i && snk_ready_o;
  assign restart   = (state_q == AST_IN_PKT) && snk_sop_i;
  assign bad_start = (state_q == AST_IDLE) && !snk_sop_i;
  assign take      = accept && !bad_start;
  // A sop inside a packet abandons the partial beat and restarts at slot 0.
  assign eff_cnt   = restart ? '0 : cnt_q;
  assign complete  = take && ((eff_cnt == CntW'(SYMBOLS_PER_BEAT - 1)) || snk_eop_i);
  assign beat_sop  = (eff_cnt == '0) ? snk_sop_i : sop_beat_q;
  assign beat_empty = snk_eop_i ?
                      EMPTY_W'(ast_empty_count(32'(eff_cnt), SYMBOLS_PER_BEAT)) : '0;

  // Slot 0 clears the other slots so padding in a short beat is always zero.
  always_comb begin
    acc_new = (eff_cnt == '0) ? '0 : acc_q;
    for (int i = 0; i < int'(SYMBOLS_PER_BEAT); i++) begin
      if (eff_cnt == CntW'(i)) begin
        acc_new[DataW-1-i*DATABITS_PER_SYMBOL -: DATABITS_PER_SYMBOL] = snk_data_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sop_beat_d = sop_beat_q;
    err_d      = accept && (bad_start || restart);
    if (take) begin
      acc_d   = acc_new;
      cnt_d   = complete ? '0 : eff_cnt + 1'b1;
      state_d = snk_eop_i ? AST_IDLE : AST_IN_PKT;
      if (eff_cnt == '0) begin
        sop_beat_d = snk_sop_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= AST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sop_beat_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sop_beat_q <= sop_beat_d;
      err_q      <= err_d;
    end
  end

  assign load_data = {acc_new, beat_sop, snk_eop_i, beat_empty};

  ast_out_reg #(
    .Width (PayW)
  ) u_out_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_valid_i (complete),
    .load_data_i  (load_data),
    .in_ready_o   (snk_ready_o),
    .out_valid_o  (src_valid_o),
    .out_data_o   (out_data),
    .out_ready_i  (src_ready_i)
  );

  assign {src_data_o, src_sop_o, src_eop_o, src_empty_o} = out_data;
  assign err_o = err_q;

`ifdef AST_PACKER_STATS_EN
  logic [15:0] pkt_cnt_q, err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (src_valid_o && src_ready_i && src_eop_o && (pkt_cnt_q != 16'hFFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (err_q && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
`else
  // Statistics counters are not built.
`endif

endmodule
